// File: rtl/whack_pkg.sv
// Shared types and widths for the whack-a-mole scoring engine.
package whack_pkg;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        LOCKED = 2'd1,
        OVER   = 2'd2
    } state_e;

    localparam int STREAK_W = 3;
    localparam int LIVES_W  = 2;

endpackage

// File: rtl/whack_score_tracker_sat_accum.sv
// Saturating/floored score accumulator: next = clamp(score + add - sub, 0, 2**SCORE_W-1).
// Kept standalone so the bonus-round block can reuse the same arithmetic.
module score_sat_accum #(
    parameter int SCORE_W = 10
) (
    input  logic [SCORE_W-1:0] score_i,
    input  logic [SCORE_W-1:0] add_i,
    input  logic [SCORE_W-1:0] sub_i,
    output logic [SCORE_W-1:0] next_o
);

    localparam logic [SCORE_W:0] SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};

    logic [SCORE_W:0] sum;
    logic [SCORE_W:0] diff;

    // Add with one guard bit, floor the subtraction at zero, then clamp at the top.
    always_comb begin
        sum    = {1'b0, score_i} + {1'b0, add_i};
        diff   = '0;
        next_o = '0;
        if (sum >= {1'b0, sub_i}) begin
            diff = sum - {1'b0, sub_i};
            if (diff > SCORE_MAX) begin
                next_o = '1;
            end else begin
                next_o = diff[SCORE_W-1:0];
            end
        end
    end

endmodule

// File: rtl/whack_score_tracker.sv
// Scoring and lives engine for the whack-a-mole game: one guess per round,
// streak multiplier, miss/timeout penalties, lives and a session high score.
module whack_score_tracker
    import whack_pkg::*;
#(
    parameter int NUM_HOLES    = 8,
    parameter int POS_W        = 3,
    parameter int SCORE_W      = 10,
    parameter int STREAK_MAX   = 4,
    parameter int MISS_PENALTY = 1,
    parameter int LIVES        = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_HOLES-1:0] mole_mask,
    input  logic                 mole_change,
    input  logic                 guess_valid,
    input  logic [POS_W-1:0]     guess_pos,
    output logic [SCORE_W-1:0]   score,
    output logic [SCORE_W-1:0]   high_score,
    output logic [STREAK_W-1:0]  streak,
    output logic [LIVES_W-1:0]   lives_left,
    output logic                 guess_ready,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 timeout_pulse,
    output logic                 game_over
);

    localparam logic [STREAK_W:0]   STREAK_CAP = (STREAK_W+1)'(STREAK_MAX);
    localparam logic [STREAK_W-1:0] STREAK_SAT = '1;
    localparam logic [LIVES_W-1:0]  LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [LIVES_W-1:0]  LAST_LIFE  = LIVES_W'(1);
    localparam logic [SCORE_W-1:0]  PENALTY    = SCORE_W'(MISS_PENALTY);

    state_e               state_q, state_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W-1:0]   high_q, high_d;
    logic [STREAK_W-1:0]  streak_q, streak_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic                 hit_q, hit_d;
    logic                 miss_q, miss_d;
    logic                 timeout_q, timeout_d;

    logic                 armed;
    logic [NUM_HOLES-1:0] shifted_mask;
    logic                 hole_up;
    logic                 hit_ev;
    logic                 miss_ev;
    logic                 timeout_ev;
    logic [STREAK_W:0]    streak_inc;
    logic [STREAK_W:0]    bonus;
    logic [SCORE_W-1:0]   add_amt;
    logic [SCORE_W-1:0]   sub_amt;
    logic [SCORE_W-1:0]   accum_next;

    // Event decode; start suppresses any guess or round end in the same cycle.
    assign armed        = (state_q == ARMED);
    assign shifted_mask = mole_mask >> guess_pos;
    assign hole_up      = (int'(guess_pos) < NUM_HOLES) && shifted_mask[0];
    assign hit_ev       = !start && armed && guess_valid && hole_up;
    assign miss_ev      = !start && armed && guess_valid && !hole_up;
    assign timeout_ev   = !start && armed && !guess_valid && mole_change && (|mole_mask);

    assign streak_inc   = {1'b0, streak_q} + 1'b1;
    assign bonus        = (streak_inc > STREAK_CAP) ? STREAK_CAP : streak_inc;
    assign add_amt      = hit_ev  ? SCORE_W'(bonus) : '0;
    assign sub_amt      = miss_ev ? PENALTY         : '0;

    score_sat_accum #(
        .SCORE_W (SCORE_W)
    ) u_accum (
        .score_i (score_q),
        .add_i   (add_amt),
        .sub_i   (sub_amt),
        .next_o  (accum_next)
    );

    // Next-state logic for the round FSM, score, streak, lives and event pulses.
    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        streak_d  = streak_q;
        lives_d   = lives_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        timeout_d = 1'b0;

        if (start) begin
            state_d  = ARMED;
            score_d  = '0;
            streak_d = '0;
            lives_d  = LIVES_INIT;
        end else begin
            case (state_q)
                ARMED: begin
                    if (hit_ev) begin
                        score_d  = accum_next;
                        streak_d = (streak_q == STREAK_SAT) ? streak_q : streak_q + 1'b1;
                        hit_d    = 1'b1;
                        state_d  = mole_change ? ARMED : LOCKED;
                    end else if (miss_ev) begin
                        score_d  = accum_next;
                        streak_d = '0;
                        lives_d  = lives_q - 1'b1;
                        miss_d   = 1'b1;
                        if (lives_q == LAST_LIFE) begin
                            state_d = OVER;
                        end else begin
                            state_d = mole_change ? ARMED : LOCKED;
                        end
                    end else if (timeout_ev) begin
                        streak_d  = '0;
                        lives_d   = lives_q - 1'b1;
                        timeout_d = 1'b1;
                        if (lives_q == LAST_LIFE) begin
                            state_d = OVER;
                        end
                    end
                end
                LOCKED: begin
                    if (mole_change) begin
                        state_d = ARMED;
                    end
                end
                OVER: begin
                    state_d = OVER;
                end
                default: begin
                    state_d = ARMED;
                end
            endcase
        end

        high_d = (score_d > high_q) ? score_d : high_q;
    end

    // State registers; reset clears everything including the high score.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARMED;
            score_q   <= '0;
            high_q    <= '0;
            streak_q  <= '0;
            lives_q   <= LIVES_INIT;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            high_q    <= high_d;
            streak_q  <= streak_d;
            lives_q   <= lives_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            timeout_q <= timeout_d;
        end
    end

    assign score         = score_q;
    assign high_score    = high_q;
    assign streak        = streak_q;
    assign lives_left    = lives_q;
    assign guess_ready   = (state_q == ARMED);
    assign hit_pulse     = hit_q;
    assign miss_pulse    = miss_q;
    assign timeout_pulse = timeout_q;
    assign game_over     = (state_q == OVER);

endmodule

// File: tb/tb_whack_score_tracker.sv
// Scoreboard bench for whack_score_tracker: a driver applies directed and random
// stimulus and queues the reference model's expected outputs; a monitor checks them.
module tb_whack_score_tracker;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] mole_mask;
    logic       mole_change;
    logic       guess_valid;
    logic [2:0] guess_pos;
    logic [9:0] score;
    logic [9:0] high_score;
    logic [2:0] streak;
    logic [1:0] lives_left;
    logic       guess_ready;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       timeout_pulse;
    logic       game_over;

    typedef struct {
        int score;
        int high;
        int streak;
        int lives;
        int ready;
        int hit;
        int miss;
        int tmo;
        int over;
    } exp_t;

    exp_t expQ[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state: phase 0 = taking guesses, 1 = guess made, 2 = game over.
    int mScore, mHigh, mStreak, mLives, mPhase;
    int mHit, mMiss, mTmo;

    whack_score_tracker #(
        .NUM_HOLES    (8),
        .POS_W        (3),
        .SCORE_W      (10),
        .STREAK_MAX   (4),
        .MISS_PENALTY (1),
        .LIVES        (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mole_mask     (mole_mask),
        .mole_change   (mole_change),
        .guess_valid   (guess_valid),
        .guess_pos     (guess_pos),
        .score         (score),
        .high_score    (high_score),
        .streak        (streak),
        .lives_left    (lives_left),
        .guess_ready   (guess_ready),
        .hit_pulse     (hit_pulse),
        .miss_pulse    (miss_pulse),
        .timeout_pulse (timeout_pulse),
        .game_over     (game_over)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Game rules written directly as arithmetic on the player's view of the game.
    task automatic modelStep(input bit r, input bit s, input logic [7:0] mask,
                             input bit mc, input bit gv, input logic [2:0] pos);
        mHit  = 0;
        mMiss = 0;
        mTmo  = 0;
        if (r) begin
            mScore = 0; mHigh = 0; mStreak = 0; mLives = 3; mPhase = 0;
        end else if (s) begin
            mScore = 0; mStreak = 0; mLives = 3; mPhase = 0;
        end else if (mPhase == 0 && gv) begin
            if (mask[pos]) begin
                mScore  = mScore + ((mStreak + 1 < 4) ? mStreak + 1 : 4);
                if (mScore > 1023) mScore = 1023;
                mStreak = (mStreak < 7) ? mStreak + 1 : 7;
                mHit    = 1;
            end else begin
                mScore  = (mScore >= 1) ? mScore - 1 : 0;
                mStreak = 0;
                mLives  = mLives - 1;
                mMiss   = 1;
            end
            if (mLives == 0) mPhase = 2;
            else mPhase = mc ? 0 : 1;
        end else if (mPhase == 0 && mc && mask != 0) begin
            mStreak = 0;
            mLives  = mLives - 1;
            mTmo    = 1;
            if (mLives == 0) mPhase = 2;
        end else if (mPhase == 1 && mc) begin
            mPhase = 0;
        end
        if (mScore > mHigh) mHigh = mScore;
    endtask

    // Drive one cycle of inputs, then queue what the outputs must show after the edge.
    task automatic applyStimulus(input bit r, input bit s, input logic [7:0] mask,
                                 input bit mc, input bit gv, input logic [2:0] pos);
        exp_t e;
        rst         = r;
        start       = s;
        mole_mask   = mask;
        mole_change = mc;
        guess_valid = gv;
        guess_pos   = pos;
        modelStep(r, s, mask, mc, gv, pos);
        e.score  = mScore;
        e.high   = mHigh;
        e.streak = mStreak;
        e.lives  = mLives;
        e.ready  = (mPhase == 0) ? 1 : 0;
        e.hit    = mHit;
        e.miss   = mMiss;
        e.tmo    = mTmo;
        e.over   = (mPhase == 2) ? 1 : 0;
        @(posedge clk);
        expQ.push_back(e);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        bit bad;
        bad = 0;
        vectors++;
        if (int'(score) != e.score) begin
            $display("[TB] FAIL score: got %0d expected %0d at %0t", score, e.score, $time); bad = 1;
        end
        if (int'(high_score) != e.high) begin
            $display("[TB] FAIL high_score: got %0d expected %0d at %0t", high_score, e.high, $time); bad = 1;
        end
        if (int'(streak) != e.streak) begin
            $display("[TB] FAIL streak: got %0d expected %0d at %0t", streak, e.streak, $time); bad = 1;
        end
        if (int'(lives_left) != e.lives) begin
            $display("[TB] FAIL lives_left: got %0d expected %0d at %0t", lives_left, e.lives, $time); bad = 1;
        end
        if (int'(guess_ready) != e.ready) begin
            $display("[TB] FAIL guess_ready: got %0d expected %0d at %0t", guess_ready, e.ready, $time); bad = 1;
        end
        if (int'(hit_pulse) != e.hit) begin
            $display("[TB] FAIL hit_pulse: got %0d expected %0d at %0t", hit_pulse, e.hit, $time); bad = 1;
        end
        if (int'(miss_pulse) != e.miss) begin
            $display("[TB] FAIL miss_pulse: got %0d expected %0d at %0t", miss_pulse, e.miss, $time); bad = 1;
        end
        if (int'(timeout_pulse) != e.tmo) begin
            $display("[TB] FAIL timeout_pulse: got %0d expected %0d at %0t", timeout_pulse, e.tmo, $time); bad = 1;
        end
        if (int'(game_over) != e.over) begin
            $display("[TB] FAIL game_over: got %0d expected %0d at %0t", game_over, e.over, $time); bad = 1;
        end
        if (bad) miscompares++;
    endtask

    // Monitor: outputs are registered every cycle, so one expectation is consumed per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Stimulus: directed scenarios first, then a long randomized game session.
    initial begin
        logic [7:0] mask;
        logic [2:0] pos;
        bit         mc, gv, s, r;
        int         first;

        rst = 1'b1; start = 1'b0; mole_mask = '0; mole_change = 1'b0;
        guess_valid = 1'b0; guess_pos = '0;
        mScore = 0; mHigh = 0; mStreak = 0; mLives = 3; mPhase = 0;
        #1;
        applyStimulus(1, 0, 8'h00, 0, 0, 3'd0);
        applyStimulus(1, 0, 8'h00, 0, 0, 3'd0);

        // First hit, then four more rounds to exercise the streak cap.
        applyStimulus(0, 0, 8'b0000_0100, 0, 1, 3'd2);
        applyStimulus(0, 0, 8'b0000_0100, 0, 0, 3'd0);
        applyStimulus(0, 0, 8'b0000_0100, 1, 0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 8'b1000_0001, 0, 1, 3'd7);
            applyStimulus(0, 0, 8'b1000_0001, 1, 0, 3'd0);
        end

        // Wrong guess at score zero.
        applyStimulus(0, 1, 8'h00, 0, 0, 3'd0);
        applyStimulus(0, 0, 8'b0010_0000, 0, 1, 3'd1);
        applyStimulus(0, 0, 8'b0010_0000, 1, 0, 3'd0);

        // Three timeouts end the game; later guesses and round ends are ignored.
        applyStimulus(0, 1, 8'h00, 0, 0, 3'd0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'b0001_0000, 1, 0, 3'd0);
        applyStimulus(0, 0, 8'b0001_0000, 0, 1, 3'd4);
        applyStimulus(0, 0, 8'b0001_0000, 1, 0, 3'd0);

        // Empty mask at round end is not a timeout.
        applyStimulus(0, 1, 8'h00, 0, 0, 3'd0);
        applyStimulus(0, 0, 8'h00, 1, 0, 3'd0);

        // Simultaneous guess + round end repeatedly until the score saturates.
        for (int i = 0; i < 300; i++) begin
            pos = 3'($urandom_range(0, 7));
            applyStimulus(0, 0, 8'hFF, 1, 1, pos);
        end
        applyStimulus(0, 1, 8'h00, 0, 0, 3'd0);
        applyStimulus(0, 0, 8'h00, 0, 0, 3'd0);

        // Randomized play with occasional start/reset and empty masks.
        mask = 8'($urandom);
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 299) == 0);
            s  = ($urandom_range(0, 59) == 0);
            mc = ($urandom_range(0, 3) == 0);
            gv = ($urandom_range(0, 2) == 0);
            pos = 3'($urandom_range(0, 7));
            if (mask != 0 && $urandom_range(0, 2) != 0) begin
                first = $urandom_range(0, 7);
                for (int k = 0; k < 8; k++) begin
                    if (mask[(first + k) % 8]) begin
                        pos = 3'((first + k) % 8);
                        break;
                    end
                end
            end
            applyStimulus(r, s, mask, mc, gv, pos);
            if (mc) mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        end

        applyStimulus(0, 0, 8'h00, 0, 0, 3'd0);
        repeat (2) @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
